// File: rtl/jtdsp16_do_loop_if.sv
// Connection bundle between the DSP16 sequencer and its hardware DO-loop unit.
// The master drives the decoded instruction and stall, and the slave returns the loop status.
interface jtdsp16_do_loop_if;
    logic        cen;
    logic        do_start;
    logic [10:0] do_data;
    logic        pc_halt;
    logic [3:0]  do_pc;
    logic        do_out;
    logic        do_busy;
    logic [6:0]  do_cnt;
    logic        nest_err;

    modport master (
        output cen, do_start, do_data, pc_halt,
        input  do_pc, do_out, do_busy, do_cnt, nest_err
    );

    modport slave (
        input  cen, do_start, do_data, pc_halt,
        output do_pc, do_out, do_busy, do_cnt, nest_err
    );
endinterface

// File: rtl/jtdsp16_do_loop.sv
// Hardware "do K {N}" sequencer. It walks a body offset 1..N for K passes.
// It raises a combinational exit strobe on the final body cycle so the ROM address unit leaves the cache on the same edge.
module jtdsp16_do_loop (
    input  logic                  clk,
    input  logic                  rst,
    jtdsp16_do_loop_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOOP  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  body_len;
    logic [3:0]  pc;
    logic [6:0]  cnt;
    logic        nest;

    logic [6:0]  req_k;
    logic [3:0]  req_n;
    logic        req_empty;
    logic        at_body_end;
    logic        last_pass;

    assign req_k       = bus.do_data[10:4];
    assign req_n       = bus.do_data[3:0];
    assign req_empty   = (req_k == 7'd0) || (req_n == 4'd0);
    assign at_body_end = (pc == body_len);
    assign last_pass   = (cnt == 7'd1);

    // A degenerate loop (K or N zero) loads nothing and only spends one cycle in FLUSH to emit the exit strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            body_len <= 4'd0;
            pc       <= 4'd0;
            cnt      <= 7'd0;
            nest     <= 1'b0;
        end else if (bus.cen) begin
            case (state)
                IDLE: begin
                    if (bus.do_start) begin
                        if (req_empty) begin
                            state <= FLUSH;
                        end else begin
                            state    <= LOOP;
                            body_len <= req_n;
                            cnt      <= req_k;
                            pc       <= 4'd1;
                        end
                    end
                end
                LOOP: begin
                    if (bus.do_start) nest <= 1'b1;
                    if (!bus.pc_halt) begin
                        if (!at_body_end) begin
                            pc <= pc + 4'd1;
                        end else if (!last_pass) begin
                            pc  <= 4'd1;
                            cnt <= cnt - 7'd1;
                        end else begin
                            state <= IDLE;
                            pc    <= 4'd0;
                            cnt   <= 7'd0;
                        end
                    end
                end
                FLUSH: begin
                    if (bus.do_start) nest <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.do_out = 1'b0;
        case (state)
            FLUSH:   bus.do_out = 1'b1;
            LOOP:    bus.do_out = at_body_end && last_pass && !bus.pc_halt;
            default: bus.do_out = 1'b0;
        endcase
    end

    assign bus.do_pc    = pc;
    assign bus.do_cnt   = cnt;
    assign bus.do_busy  = (state == LOOP);
    assign bus.nest_err = nest;

endmodule

// File: tb/tb_jtdsp16_do_loop.sv
// Directed self-checking bench for jtdsp16_do_loop.
// Expected values are written by hand from the loop behaviour.
module tb_jtdsp16_do_loop;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    int   pulses;

    jtdsp16_do_loop_if bus ();

    jtdsp16_do_loop dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compareOne(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] exp_pc, input logic [6:0] exp_cnt,
                               input logic exp_out, input logic exp_busy, input logic exp_nest);
        compareOne({tag, ".do_pc"},    {3'd0, bus.do_pc},    {3'd0, exp_pc});
        compareOne({tag, ".do_cnt"},   bus.do_cnt,           exp_cnt);
        compareOne({tag, ".do_out"},   {6'd0, bus.do_out},   {6'd0, exp_out});
        compareOne({tag, ".do_busy"},  {6'd0, bus.do_busy},  {6'd0, exp_busy});
        compareOne({tag, ".nest_err"}, {6'd0, bus.nest_err}, {6'd0, exp_nest});
    endtask

    task automatic applyStimulus(input logic cen, input logic start, input logic [6:0] k,
                                 input logic [3:0] n, input logic halt);
        bus.cen      = cen;
        bus.do_start = start;
        bus.do_data  = {k, n};
        bus.pc_halt  = halt;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        pulses     = 0;
        rst        = 1'b1;
        applyStimulus(1'b1, 1'b0, 7'd0, 4'd0, 1'b0);
        tick;
        tick;
        checkOutput("reset", 4'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick;
        checkOutput("after_reset", 4'd0, 7'd0, 1'b0, 1'b0, 1'b0);

        // K=2, N=3 with cen held high
        applyStimulus(1'b1, 1'b1, 7'd2, 4'd3, 1'b0);
        checkOutput("k2n3_start", 4'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        tick;
        applyStimulus(1'b1, 1'b0, 7'd0, 4'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("k2n3_body%0d", i + 1), 4'((i % 3) + 1),
                        (i < 3) ? 7'd2 : 7'd1, i == 5, 1'b1, 1'b0);
            tick;
        end
        checkOutput("k2n3_exit", 4'd0, 7'd0, 1'b0, 1'b0, 1'b0);

        // K=1, N=4 with cen gaps and a stall on the third body cycle
        applyStimulus(1'b1, 1'b1, 7'd1, 4'd4, 1'b1);
        tick;
        applyStimulus(1'b1, 1'b0, 7'd0, 4'd0, 1'b0);
        checkOutput("k1n4_c1", 4'd1, 7'd1, 1'b0, 1'b1, 1'b0);
        tick;
        applyStimulus(1'b0, 1'b0, 7'd0, 4'd0, 1'b0);
        checkOutput("k1n4_cen0a", 4'd2, 7'd1, 1'b0, 1'b1, 1'b0);
        tick;
        applyStimulus(1'b1, 1'b0, 7'd0, 4'd0, 1'b0);
        checkOutput("k1n4_c2", 4'd2, 7'd1, 1'b0, 1'b1, 1'b0);
        tick;
        applyStimulus(1'b0, 1'b0, 7'd0, 4'd0, 1'b0);
        checkOutput("k1n4_cen0b", 4'd3, 7'd1, 1'b0, 1'b1, 1'b0);
        tick;
        applyStimulus(1'b1, 1'b0, 7'd0, 4'd0, 1'b1);
        checkOutput("k1n4_halt3", 4'd3, 7'd1, 1'b0, 1'b1, 1'b0);
        tick;
        applyStimulus(1'b1, 1'b0, 7'd0, 4'd0, 1'b0);
        checkOutput("k1n4_c3", 4'd3, 7'd1, 1'b0, 1'b1, 1'b0);
        tick;
        applyStimulus(1'b1, 1'b0, 7'd0, 4'd0, 1'b1);
        checkOutput("k1n4_halt4", 4'd4, 7'd1, 1'b0, 1'b1, 1'b0);
        tick;
        applyStimulus(1'b1, 1'b0, 7'd0, 4'd0, 1'b0);
        checkOutput("k1n4_c4", 4'd4, 7'd1, 1'b1, 1'b1, 1'b0);
        tick;
        checkOutput("k1n4_exit", 4'd0, 7'd0, 1'b0, 1'b0, 1'b0);

        // Degenerate descriptors pass through FLUSH
        applyStimulus(1'b1, 1'b1, 7'd0, 4'd5, 1'b0);
        tick;
        applyStimulus(1'b1, 1'b0, 7'd0, 4'd0, 1'b1);
        checkOutput("k0n5_flush", 4'd0, 7'd0, 1'b1, 1'b0, 1'b0);
        tick;
        checkOutput("k0n5_idle", 4'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 7'd3, 4'd0, 1'b0);
        tick;
        applyStimulus(1'b1, 1'b0, 7'd0, 4'd0, 1'b0);
        checkOutput("k3n0_flush", 4'd0, 7'd0, 1'b1, 1'b0, 1'b0);
        tick;
        checkOutput("k3n0_idle", 4'd0, 7'd0, 1'b0, 1'b0, 1'b0);

        // A maximal loop with K=127 and N=15 runs 1905 body cycles and gives a single exit strobe
        applyStimulus(1'b1, 1'b1, 7'd127, 4'd15, 1'b0);
        tick;
        applyStimulus(1'b1, 1'b0, 7'd0, 4'd0, 1'b0);
        for (int i = 0; i < 1905; i++) begin
            compareOne("max_pc", {3'd0, bus.do_pc}, {3'd0, 4'((i % 15) + 1)});
            compareOne("max_cnt", bus.do_cnt, 7'(127 - (i / 15)));
            if (bus.do_out) pulses++;
            tick;
        end
        compareOne("max_pulses", 7'(pulses), 7'd1);
        checkOutput("max_exit", 4'd0, 7'd0, 1'b0, 1'b0, 1'b0);

        // A reset with cen low on the fourth body cycle aborts the loop
        applyStimulus(1'b1, 1'b1, 7'd2, 4'd3, 1'b0);
        tick;
        applyStimulus(1'b1, 1'b0, 7'd0, 4'd0, 1'b0);
        tick;
        tick;
        tick;
        checkOutput("abort_body4", 4'd1, 7'd1, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 7'd0, 4'd0, 1'b0);
        tick;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 7'd0, 4'd0, 1'b0);
        checkOutput("abort_idle", 4'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        tick;
        checkOutput("abort_stay", 4'd0, 7'd0, 1'b0, 1'b0, 1'b0);

        // A nested do_start sets a sticky error and leaves the running loop untouched
        applyStimulus(1'b1, 1'b1, 7'd2, 4'd3, 1'b0);
        tick;
        applyStimulus(1'b1, 1'b0, 7'd0, 4'd0, 1'b0);
        checkOutput("nest_b1", 4'd1, 7'd2, 1'b0, 1'b1, 1'b0);
        tick;
        applyStimulus(1'b1, 1'b1, 7'd5, 4'd7, 1'b0);
        checkOutput("nest_b2", 4'd2, 7'd2, 1'b0, 1'b1, 1'b0);
        tick;
        applyStimulus(1'b1, 1'b0, 7'd0, 4'd0, 1'b0);
        for (int i = 2; i < 6; i++) begin
            checkOutput($sformatf("nest_b%0d", i + 1), 4'((i % 3) + 1),
                        (i < 3) ? 7'd2 : 7'd1, i == 5, 1'b1, 1'b1);
            tick;
        end
        checkOutput("nest_exit", 4'd0, 7'd0, 1'b0, 1'b0, 1'b1);
        tick;
        checkOutput("nest_sticky", 4'd0, 7'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checkOutput("nest_clear", 4'd0, 7'd0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/jtdsp16_do_loop.md
JTDSP16_DO_LOOP -- requirements
Module: jtdsp16_do_loop

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cen  in  1  clock enable; state advances only on edges with cen=1.
REQ-005 do_start  in  1  decoded "do K {N}" instruction executing this cycle.
REQ-006 do_data  in  11  loop descriptor: [10:4]=K iteration count, [3:0]=N body length.
REQ-007 pc_halt  in  1  pipeline stall; freezes loop sequencing.
REQ-008 do_pc  out  4  body offset fed to the ROM address unit; 1..N while looping, 0 when idle.
REQ-009 do_out  out  1  loop-exit strobe to the ROM address unit.
REQ-010 do_busy  out  1  high while a loop is active.
REQ-011 do_cnt  out  7  iterations remaining, including the current one; 0 when idle.
REQ-012 nest_err  out  1  sticky flag: do_start seen while busy.

Function
REQ-013 States: IDLE, LOOP, FLUSH.
REQ-014 IDLE, cen=1, do_start=1, K!=0 and N!=0 -> LOOP: latch N, do_cnt<=K, do_pc<=1.
REQ-015 IDLE, cen=1, do_start=1, K==0 or N==0 -> FLUSH; no registers loaded except state.
REQ-016 FLUSH: do_out=1 combinationally; on the next cen edge go to IDLE regardless of pc_halt.
REQ-017 LOOP, cen=1, pc_halt=0, do_pc<N -> do_pc<=do_pc+1.
REQ-018 LOOP, cen=1, pc_halt=0, do_pc==N, do_cnt>1 -> do_pc<=1, do_cnt<=do_cnt-1.
REQ-019 LOOP, cen=1, pc_halt=0, do_pc==N, do_cnt==1 -> IDLE, do_pc<=0, do_cnt<=0.
REQ-020 do_out in LOOP = (do_pc==N) and (do_cnt==1) and !pc_halt; combinational, so the ROM address unit leaves the cache on the same edge.
REQ-021 do_out is low in IDLE.
REQ-022 pc_halt=1 or cen=0 in LOOP: all registers hold; do_out low while pc_halt=1.
REQ-023 do_start while in LOOP or FLUSH is ignored: the loop continues unchanged and nest_err<=1 on that cen edge.
REQ-024 nest_err clears only on rst.
REQ-025 do_busy = (state==LOOP).
REQ-026 do_start with pc_halt=1 in IDLE is still accepted.
REQ-027 do_pc arithmetic is 4-bit; it never exceeds N, and 15 is a legal N.
REQ-028 do_cnt arithmetic is 7-bit and never underflows; K=127 gives 127 body passes.
REQ-029 Total body cycles per loop = N*K unstalled cen cycles; do_out asserts exactly once per loop.

Reset
REQ-030 rst=1 at a clk edge, regardless of cen, forces: state IDLE, do_pc=0, do_cnt=0, do_out=0, do_busy=0, nest_err=0.
REQ-031 rst mid-LOOP or mid-FLUSH aborts the loop; no do_out pulse is generated for the aborted loop.
REQ-032 Outputs are defined (not X) in the first cycle after rst deasserts.

Verification
REQ-033 do_start with do_data={K=2,N=3}, cen=1 throughout -> do_pc sequence 1,2,3,1,2,3 then 0; do_cnt 2,2,2,1,1,1,0; do_out high only on the 6th cycle.
REQ-034 K=1,N=4, cen toggling 1/0 and pc_halt=1 on the 3rd body cycle -> do_pc holds during stall; do_out stays low while halted; exit after exactly 4 effective cycles.
REQ-035 do_data={K=0,N=5} -> one cycle with do_out=1 and do_busy=0, then IDLE with do_pc=0; same for {K=3,N=0}.
REQ-036 K=127,N=15 -> 1905 body cycles; do_cnt decrements at each wrap; single do_out at the end.
REQ-037 rst asserted at the 4th body cycle of {K=2,N=3} -> next cycle IDLE, all outputs 0, no do_out.
REQ-038 Second do_start mid-loop -> nest_err=1 and stays 1; original do_pc/do_cnt sequence unaffected; nest_err cleared only by rst.
